// File: rtl/dmem_stall.sv
// Multi-cycle data memory behind the single-cycle datapath: fixed-latency word RAM
// with a combinational stall that holds the PC, plus misaligned-access detection.
module dmem_stall #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic          mis_q;
    logic [31:0]   rdata_q;
    logic          misalign_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic [AW-1:0] idx_in;
    logic          mis_in;
    logic          finish_c;
    logic [AW-1:0] acc_idx;
    logic          acc_wr;
    logic          acc_mis;
    logic          unused_addr;

    assign req         = memread | memwrite;
    assign idx_in      = addr[AW+1:2];
    assign mis_in      = (addr[1:0] != 2'b00);
    assign unused_addr = ^addr[31:AW+2];

    // Access completes on this edge; with unit latency it completes straight from IDLE.
    always_comb begin
        finish_c = 1'b0;
        acc_idx  = idx_q;
        acc_wr   = wr_q;
        acc_mis  = mis_q;
        if (state_q == IDLE) begin
            finish_c = req && (LATENCY == 1);
            acc_idx  = idx_in;
            acc_wr   = memwrite;
            acc_mis  = mis_in;
        end else if (state_q == BUSY) begin
            finish_c = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            mis_q      <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= idx_in;
                        wdata_q <= wdata;
                        wr_q    <= memwrite;
                        mis_q   <= mis_in;
                        if (LATENCY == 1) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(LATENCY - 2);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                // The held instruction still drives req here; it must not restart.
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (finish_c) begin
                misalign_q <= acc_mis;
                if (!acc_wr) begin
                    rdata_q <= acc_mis ? 32'h0 : mem[acc_idx];
                end
            end
        end
    end

    // Store commits on the edge leaving DONE, alongside the datapath PC advance.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == DONE) && wr_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign stall    = !reset && (((state_q == IDLE) && req) || (state_q == BUSY));
    assign rdata    = rdata_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_stall.sv
// Bench for dmem_stall: three instances (latency 1..3) driven by one stimulus process,
// checked by a scoreboard monitor against a word-array memory model.
module tb_dmem_stall;

    localparam int unsigned NI = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_a    [NI];
    logic        memread_a  [NI];
    logic        memwrite_a [NI];
    logic [31:0] addr_a     [NI];
    logic [31:0] wdata_a    [NI];
    logic [31:0] rdata_a    [NI];
    logic        stall_a    [NI];
    logic        misalign_a [NI];

    logic [31:0] mdl     [NI][64];
    logic [31:0] last_rd [NI];
    exp_t        q       [NI][$];
    int          run_c   [NI];

    int n_chk = 0;
    int n_fail = 0;
    bit end_flag = 1'b0;
    bit mon_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_stall #(.DEPTH_WORDS(64), .LATENCY(g + 1)) u_dut (
            .clk      (clk),
            .reset    (reset_a[g]),
            .memread  (memread_a[g]),
            .memwrite (memwrite_a[g]),
            .addr     (addr_a[g]),
            .wdata    (wdata_a[g]),
            .rdata    (rdata_a[g]),
            .stall    (stall_a[g]),
            .misalign (misalign_a[g])
        );
    end

    task automatic check(input bit ok, input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s [latency %0d] at %0t: got %h, expected %h", name, inst + 1, $time, act, req);
        end
    endtask

    // Scoreboard monitor: a falling stall with the request held marks the DONE cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (reset_a[i]) begin
                check(stall_a[i] == 1'b0, "stall_in_reset", i, 32'(stall_a[i]), 32'h0);
                run_c[i] = 0;
            end else if (stall_a[i]) begin
                run_c[i]++;
                if (run_c[i] > i + 1) begin
                    check(1'b0, "stall_too_long", i, 32'(run_c[i]), 32'(i + 1));
                    run_c[i] = 0;
                end
            end else if (run_c[i] != 0) begin
                if (q[i].size() == 0) begin
                    check(1'b0, "unexpected_done", i, 32'(run_c[i]), 32'h0);
                end else begin
                    e = q[i].pop_front();
                    check(run_c[i] == i + 1, "stall_cycles", i, 32'(run_c[i]), 32'(i + 1));
                    check(rdata_a[i] === e.rdata, "rdata", i, rdata_a[i], e.rdata);
                    check(misalign_a[i] === e.mis, "misalign_done", i, 32'(misalign_a[i]), 32'(e.mis));
                end
                run_c[i] = 0;
            end else begin
                check(misalign_a[i] == 1'b0, "misalign_idle", i, 32'(misalign_a[i]), 32'h0);
            end
        end
        if (end_flag && !mon_done) begin
            for (int i = 0; i < NI; i++) begin
                check(q[i].size() == 0, "pending_expect", i, 32'(q[i].size()), 32'h0);
            end
            mon_done = 1'b1;
        end
    end

    // One access: model result is queued, request held until stall falls, then one DONE cycle.
    task automatic issue(input int i, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        int   n;
        memread_a[i]  = rd;
        memwrite_a[i] = wr;
        addr_a[i]     = a;
        wdata_a[i]    = d;
        idx   = int'((a >> 2) % 64);
        e.mis = (a % 4) != 0;
        if (wr) begin
            if (!e.mis) mdl[i][idx] = d;
            e.rdata = last_rd[i];
        end else begin
            e.rdata    = e.mis ? 32'h0 : mdl[i][idx];
            last_rd[i] = e.rdata;
        end
        q[i].push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (stall_a[i]) begin
                addr_a[i]  = $urandom;
                wdata_a[i] = $urandom;
            end
        end while (stall_a[i] && n < 10);
        @(posedge clk); #1;
        memread_a[i]  = 1'b0;
        memwrite_a[i] = 1'b0;
    endtask

    // Store interrupted by reset sampled on edge j after the request appears (j <= latency).
    task automatic abort_wr(input int i, input int j, input logic [31:0] a, input logic [31:0] d);
        memread_a[i]  = 1'b0;
        memwrite_a[i] = 1'b1;
        addr_a[i]     = a;
        wdata_a[i]    = d;
        repeat (j - 1) begin
            @(posedge clk); #1;
        end
        reset_a[i]    = 1'b1;
        memwrite_a[i] = 1'b0;
        @(posedge clk); #1;
        reset_a[i] = 1'b0;
        last_rd[i] = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [31:0] a;
        for (int i = 0; i < NI; i++) begin
            reset_a[i]    = 1'b1;
            memread_a[i]  = 1'b0;
            memwrite_a[i] = 1'b0;
            addr_a[i]     = '0;
            wdata_a[i]    = '0;
            last_rd[i]    = '0;
            run_c[i]      = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) reset_a[i] = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 64; w++) issue(i, 1'b0, 1'b1, 32'(w * 4), $urandom);

            issue(i, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
            issue(i, 1'b1, 1'b0, 32'h10, 32'h0);
            issue(i, 1'b0, 1'b1, 32'h4, 32'h12345678);
            issue(i, 1'b1, 1'b0, 32'h4, 32'h0);
            issue(i, 1'b1, 1'b0, 32'h8, 32'h0);
            issue(i, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF);
            issue(i, 1'b1, 1'b0, 32'h10, 32'h0);
            issue(i, 1'b1, 1'b0, 32'h11, 32'h0);
            issue(i, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5);
            issue(i, 1'b1, 1'b0, 32'h0, 32'h0);
            abort_wr(i, i + 1, 32'h20, 32'h55AA55AA);
            issue(i, 1'b1, 1'b0, 32'h20, 32'h0);
            issue(i, 1'b1, 1'b1, 32'h24, 32'h0BADF00D);
            issue(i, 1'b1, 1'b0, 32'h24, 32'h0);

            for (int k = 0; k < 120; k++) begin
                a = $urandom & 32'h3FF;
                if ($urandom_range(3, 0) != 0) a = a & 32'hFFFF_FFFC;
                if ($urandom_range(15, 0) == 0) begin
                    abort_wr(i, int'($urandom_range(i + 1, 1)), a, $urandom);
                end else begin
                    op = int'($urandom_range(2, 0));
                    issue(i, op != 1, op != 0, a, $urandom);
                end
                repeat ($urandom_range(2, 0)) begin
                    @(posedge clk); #1;
                end
            end
            repeat (2) @(posedge clk);
            #1;
        end

        end_flag = 1'b1;
        wait (mon_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
